// File: rtl/video_timing_checker.sv
// video_timing_checker: receive-side monitor for the parallel video bus.
// Measures line/frame timing, locks on stable timing, checks test patterns.
module video_timing_checker #(
  parameter int CW = 16,
  parameter int DW = 24
) (
  input  logic          px_clk,
  input  logic          rstn,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          dval,
  input  logic [DW-1:0] px_data,
  input  logic [1:0]    psel,
  input  logic          clr,
  output logic [CW-1:0] meas_h_total,
  output logic [CW-1:0] meas_h_act,
  output logic [CW-1:0] meas_v_total,
  output logic [CW-1:0] meas_v_act,
  output logic          locked,
  output logic          timing_err,
  output logic          pix_err,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] pix_err_cnt,
  output logic [CW-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    SEARCH,
    ACQ,
    LOCKED
  } state_t;

  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [DW-1:0] STEP3 = DW'(24'h111111);

  function automatic logic [CW-1:0] sat_inc(
    input logic [CW-1:0] v
  );
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  state_t        state;
  logic          hs_d;
  logic          vs_d;
  logic          hs_rise;
  logic          vs_rise;
  logic          seen_hs;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] d_cnt;
  logic [CW-1:0] v_cnt;
  logic [CW-1:0] va_cnt;
  logic [CW-1:0] ref_ht;
  logic [CW-1:0] ref_ha;
  logic [CW-1:0] ref_vt;
  logic [CW-1:0] ref_va;
  logic [CW-1:0] ht_nx;
  logic [CW-1:0] ha_nx;
  logic [1:0]    pat_mode;
  logic [DW-1:0] exp_px;
  logic [DW-1:0] step;
  logic          line_first;
  logic          same;
  logic          nz;
  logic          pe_c;
  logic          te_c;

  assign hs_rise = hsync & ~hs_d;
  assign vs_rise = vsync & ~vs_d;

  // Closing-frame values include the line that ends on this very edge
  always_comb begin
    line_first = dval & (hs_rise | (d_cnt == '0));
    ht_nx = (hs_rise && seen_hs) ? h_cnt : meas_h_total;
    ha_nx = (hs_rise && d_cnt != '0) ? d_cnt : meas_h_act;
    same = (ht_nx == ref_ht) && (ha_nx == ref_ha) &&
           (v_cnt == ref_vt) && (va_cnt == ref_va);
    nz = (ht_nx != '0) && (ha_nx != '0) &&
         (v_cnt != '0) && (va_cnt != '0);
    te_c = vs_rise && (state == LOCKED) && !same;
    step = (pat_mode == 2'd3) ? STEP3 : DW'(1);
    pe_c = 1'b0;
    if (dval) begin
      unique case (pat_mode)
        2'd0: pe_c = 1'b0;
        2'd2: pe_c = !line_first && (px_data != exp_px);
        default: begin
          if (line_first) pe_c = (px_data != '0);
          else            pe_c = (px_data != exp_px);
        end
      endcase
    end
  end

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      hs_d         <= 1'b0;
      vs_d         <= 1'b0;
      seen_hs      <= 1'b0;
      h_cnt        <= '0;
      d_cnt        <= '0;
      meas_h_total <= '0;
      meas_h_act   <= '0;
    end else begin
      hs_d <= hsync;
      vs_d <= vsync;
      if (hs_rise) begin
        seen_hs      <= 1'b1;
        meas_h_total <= ht_nx;
        meas_h_act   <= ha_nx;
        h_cnt        <= CW'(1);
        d_cnt        <= dval ? CW'(1) : '0;
      end else begin
        h_cnt <= sat_inc(h_cnt);
        if (dval) d_cnt <= sat_inc(d_cnt);
      end
    end
  end

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      v_cnt        <= '0;
      va_cnt       <= '0;
      meas_v_total <= '0;
      meas_v_act   <= '0;
      pat_mode     <= 2'd0;
    end else if (vs_rise) begin
      meas_v_total <= v_cnt;
      meas_v_act   <= va_cnt;
      v_cnt        <= hs_rise ? CW'(1) : '0;
      va_cnt       <= line_first ? CW'(1) : '0;
      pat_mode     <= psel;
    end else begin
      if (hs_rise)    v_cnt  <= sat_inc(v_cnt);
      if (line_first) va_cnt <= sat_inc(va_cnt);
    end
  end

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      state      <= SEARCH;
      locked     <= 1'b0;
      timing_err <= 1'b0;
      ref_ht     <= '0;
      ref_ha     <= '0;
      ref_vt     <= '0;
      ref_va     <= '0;
    end else begin
      timing_err <= 1'b0;
      if (vs_rise) begin
        unique case (state)
          SEARCH: state <= ACQ;
          ACQ: begin
            ref_ht <= ht_nx;
            ref_ha <= ha_nx;
            ref_vt <= v_cnt;
            ref_va <= va_cnt;
            if (same && nz) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (!same) begin
              timing_err <= 1'b1;
              ref_ht     <= ht_nx;
              ref_ha     <= ha_nx;
              ref_vt     <= v_cnt;
              ref_va     <= va_cnt;
              state      <= ACQ;
              locked     <= 1'b0;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Expected value follows the pattern, not the received data
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      exp_px  <= '0;
      pix_err <= 1'b0;
    end else begin
      pix_err <= pe_c;
      if (dval) begin
        if (line_first)
          exp_px <= (pat_mode == 2'd2) ? px_data : step;
        else if (pat_mode != 2'd2)
          exp_px <= exp_px + step;
      end
    end
  end

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt     <= '0;
      pix_err_cnt <= '0;
      frame_cnt   <= '0;
    end else if (clr) begin
      err_cnt     <= '0;
      pix_err_cnt <= '0;
      frame_cnt   <= '0;
    end else begin
      if (te_c)    err_cnt     <= sat_inc(err_cnt);
      if (pe_c)    pix_err_cnt <= sat_inc(pix_err_cnt);
      if (vs_rise) frame_cnt   <= frame_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_video_timing_checker.sv
// tb_video_timing_checker: directed bench for video_timing_checker.
// 20 clk/line, 12 dval, 10 lines/frame, 6 active lines.
module tb_video_timing_checker;

  localparam int CW = 16;
  localparam int DW = 24;

  logic          px_clk = 1'b0;
  logic          rstn = 1'b0;
  logic          hsync = 1'b0;
  logic          vsync = 1'b0;
  logic          dval = 1'b0;
  logic [DW-1:0] px_data = '0;
  logic [1:0]    psel = 2'd0;
  logic          clr = 1'b0;
  logic [CW-1:0] meas_h_total;
  logic [CW-1:0] meas_h_act;
  logic [CW-1:0] meas_v_total;
  logic [CW-1:0] meas_v_act;
  logic          locked;
  logic          timing_err;
  logic          pix_err;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] pix_err_cnt;
  logic [CW-1:0] frame_cnt;

  int npass = 0;
  int nchk = 0;
  int cyc = 0;
  int pe_cnt = 0;
  int te_cnt = 0;
  int pe_last = -1;
  int te_last = -1;
  int bad_cyc = -1;
  int vs_cyc = -1;
  int dmode = 1;

  video_timing_checker #(.CW(CW), .DW(DW)) dut (
    .px_clk       (px_clk),
    .rstn         (rstn),
    .hsync        (hsync),
    .vsync        (vsync),
    .dval         (dval),
    .px_data      (px_data),
    .psel         (psel),
    .clr          (clr),
    .meas_h_total (meas_h_total),
    .meas_h_act   (meas_h_act),
    .meas_v_total (meas_v_total),
    .meas_v_act   (meas_v_act),
    .locked       (locked),
    .timing_err   (timing_err),
    .pix_err      (pix_err),
    .err_cnt      (err_cnt),
    .pix_err_cnt  (pix_err_cnt),
    .frame_cnt    (frame_cnt)
  );

  always #5 px_clk = ~px_clk;

  always @(posedge px_clk) cyc <= cyc + 1;

  always @(negedge px_clk) begin
    if (rstn) begin
      if (pix_err) begin
        pe_cnt  = pe_cnt + 1;
        pe_last = cyc;
      end
      if (timing_err) begin
        te_cnt  = te_cnt + 1;
        te_last = cyc;
      end
    end
  end

  function automatic logic [DW-1:0] gen(input int k);
    case (dmode)
      3:       return DW'(k * 32'h111111);
      2:       return 24'h5A5A5A;
      default: return DW'(k);
    endcase
  endfunction

  task automatic drive_line(input bit vs, input bit act,
                            input int bad_idx,
                            input logic [DW-1:0] bad_val);
    for (int c = 0; c < 20; c++) begin
      @(negedge px_clk);
      hsync   = (c < 2);
      vsync   = vs && (c < 3);
      dval    = act && (c >= 4) && (c < 16);
      px_data = dval ? gen(c - 4) : '0;
      if (dval && (c - 4) == bad_idx) begin
        px_data = bad_val;
        bad_cyc = cyc;
      end
      if (vs && c == 0) vs_cyc = cyc;
    end
  endtask

  task automatic drive_frame(input int n, input int bad_line,
                             input int bad_idx,
                             input logic [DW-1:0] bad_val);
    for (int l = 0; l < n; l++)
      drive_line(l == 0, (l >= 2) && (l < 8),
                 (l == bad_line) ? bad_idx : -1, bad_val);
  endtask

  task automatic chk(input string name, input longint act,
                     input longint req);
    nchk++;
    if (act !== req)
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    else
      npass++;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge px_clk);
    nchk++;
    if ({meas_h_total, meas_h_act, meas_v_total, meas_v_act, locked,
         timing_err, pix_err, err_cnt, pix_err_cnt, frame_cnt} !== '0)
      $display("FAIL reset_state: outputs not all zero");
    else
      npass++;
    rstn = 1'b1;
    @(negedge px_clk);
  endtask

  task automatic test_timing();
    psel  = 2'd1;
    dmode = 1;
    drive_frame(10, -1, -1, '0);
    drive_frame(10, -1, -1, '0);
    chk("locked_early", locked, 0);
    drive_frame(10, -1, -1, '0);
    chk("h_total", meas_h_total, 20);
    chk("h_act", meas_h_act, 12);
    chk("v_total", meas_v_total, 10);
    chk("v_act", meas_v_act, 6);
    chk("locked", locked, 1);
    chk("err_cnt0", err_cnt, 0);
    chk("frame_cnt", frame_cnt, 3);
    chk("no_pix_err", pe_cnt, 0);
  endtask

  task automatic test_ramp();
    int pe0;
    pe0 = pe_cnt;
    drive_frame(10, 3, 5, 24'h000009);
    chk("ramp_pulses", pe_cnt - pe0, 1);
    chk("ramp_latency", pe_last, bad_cyc + 1);
    chk("ramp_pix_cnt", pix_err_cnt, 1);
    chk("ramp_locked", locked, 1);
  endtask

  task automatic test_mode3();
    int pe0;
    pe0   = pe_cnt;
    psel  = 2'd3;
    dmode = 3;
    drive_frame(10, -1, -1, '0);
    for (int l = 0; l < 10; l++) begin
      if (l == 5) psel = 2'd1;
      drive_line(l == 0, (l >= 2) && (l < 8), -1, '0);
    end
    chk("mode3_pulses", pe_cnt - pe0, 0);
    chk("mode3_pix_cnt", pix_err_cnt, 1);
    dmode = 1;
  endtask

  task automatic test_drift();
    int te0;
    te0 = te_cnt;
    drive_frame(11, -1, -1, '0);
    drive_frame(10, -1, -1, '0);
    chk("drift_pulses", te_cnt - te0, 1);
    chk("drift_latency", te_last, vs_cyc + 1);
    chk("drift_err_cnt", err_cnt, 1);
    chk("drift_unlock", locked, 0);
    chk("drift_v_total", meas_v_total, 11);
    drive_frame(10, -1, -1, '0);
    chk("drift_acq", locked, 0);
    drive_frame(10, -1, -1, '0);
    chk("relock", locked, 1);
    chk("relock_v_total", meas_v_total, 10);
    chk("relock_err_cnt", err_cnt, 1);
    chk("relock_pulses", te_cnt - te0, 1);
  endtask

  task automatic test_sat_clr();
    for (int i = 0; i < 70000; i++) begin
      @(negedge px_clk);
      hsync   = 1'b0;
      vsync   = 1'b0;
      dval    = 1'b1;
      px_data = '1;
    end
    @(negedge px_clk);
    chk("pix_sat", pix_err_cnt, 16'hFFFF);
    clr = 1'b1;
    @(negedge px_clk);
    chk("clr_pix_cnt", pix_err_cnt, 0);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_frame_cnt", frame_cnt, 0);
    chk("clr_locked", locked, 1);
    chk("clr_h_total", meas_h_total, 20);
    clr     = 1'b0;
    dval    = 1'b0;
    px_data = '0;
  endtask

  task automatic test_reset_mid();
    int pe0;
    int te0;
    for (int l = 0; l < 4; l++)
      drive_line(l == 0, l >= 2, -1, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge px_clk);
      hsync   = (i < 2);
      dval    = (i >= 4);
      px_data = gen(i - 4);
    end
    rstn = 1'b0;
    repeat (3) @(negedge px_clk);
    nchk++;
    if ({meas_h_total, meas_h_act, meas_v_total, meas_v_act, locked,
         timing_err, pix_err, err_cnt, pix_err_cnt, frame_cnt} !== '0)
      $display("FAIL reset_mid: outputs not all zero");
    else
      npass++;
    dval    = 1'b0;
    hsync   = 1'b0;
    px_data = '0;
    rstn    = 1'b1;
    pe0 = pe_cnt;
    te0 = te_cnt;
    for (int l = 5; l < 10; l++)
      drive_line(1'b0, l < 8, -1, '0);
    drive_frame(10, -1, -1, '0);
    drive_frame(10, -1, -1, '0);
    chk("rst_not_locked", locked, 0);
    drive_frame(10, -1, -1, '0);
    chk("rst_relock", locked, 1);
    chk("rst_te_pulses", te_cnt - te0, 0);
    chk("rst_pe_pulses", pe_cnt - pe0, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_pix_cnt", pix_err_cnt, 0);
    chk("rst_frame_cnt", frame_cnt, 3);
  endtask

  initial begin
    test_reset();
    test_timing();
    test_ramp();
    test_mode3();
    test_drift();
    test_sat_clr();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
